// File: rtl/matmul_bus_pkg.sv
// Shared types and address-map helpers for the byte-bus matrix multiply engine.
// Region bases are functions of the matrix dimension so every instance derives its own map.
package matmul_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        RG_A    = 3'd0,
        RG_B    = 3'd1,
        RG_C    = 3'd2,
        RG_CSR  = 3'd3,
        RG_NONE = 3'd4
    } region_t;

    localparam int CSR_ACC_BIT  = 0;
    localparam int CSR_BUSY_BIT = 1;
    localparam int CSR_DONE_BIT = 2;
    localparam int CSR_ERR_BIT  = 4;

    function automatic int a_base(input int n);
        return 0 * n;
    endfunction

    function automatic int b_base(input int n);
        return 2 * n * n;
    endfunction

    function automatic int c_base(input int n);
        return 3 * n * n;
    endfunction

    function automatic int csr_addr(input int n);
        return 7 * n * n;
    endfunction

endpackage

// File: rtl/matmul_byte_bus_engine_mac_row.sv
// One row of N multiply-accumulate lanes: c_next[j] = c_cur[j] + a_val * b_row[j].
// Products are sign- or zero-extended to the accumulator width; the sum wraps.
module mac_row #(
    parameter int N      = 4,
    parameter int A_W    = 16,
    parameter int B_W    = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic [A_W-1:0]     a_val,
    input  logic [N*B_W-1:0]   b_row,
    input  logic [N*ACC_W-1:0] c_cur,
    output logic [N*ACC_W-1:0] c_next
);

    localparam int P_W = A_W + B_W;

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [B_W-1:0]   b_s;
        logic [P_W-1:0]   prod_s;
        logic [ACC_W-1:0] ext_s;

        assign b_s = b_row[j*B_W +: B_W];

        if (SIGNED != 0) begin : g_signed
            assign prod_s = P_W'($signed(a_val)) * P_W'($signed(b_s));
            assign ext_s  = {{(ACC_W-P_W){prod_s[P_W-1]}}, prod_s};
        end else begin : g_unsigned
            assign prod_s = P_W'(a_val) * P_W'(b_s);
            assign ext_s  = {{(ACC_W-P_W){1'b0}}, prod_s};
        end

        assign c_next[j*ACC_W +: ACC_W] = c_cur[j*ACC_W +: ACC_W] + ext_s;
    end

endmodule

// File: rtl/matmul_byte_bus_engine.sv
// Byte-addressed host port over A/B/C matrix storage plus a CSR; on start computes
// C = A*B (or C += A*B) one A element per cycle, updating a full C row in parallel.
module matmul_byte_bus_engine
    import matmul_bus_pkg::*;
#(
    parameter int N      = 4,
    parameter int A_W    = 16,
    parameter int B_W    = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_in,
    input  logic              write_en,
    input  logic              read_en,
    output logic [7:0]        data_out,
    input  logic              start,
    output logic              ready,
    output logic              done
);

    localparam int NN = N * N;
    localparam int EW = (NN > 1) ? $clog2(NN) : 1;
    localparam int IW = $clog2(N);
    localparam logic [ADDR_W-1:0] B_BASE   = ADDR_W'(b_base(N));
    localparam logic [ADDR_W-1:0] C_BASE   = ADDR_W'(c_base(N));
    localparam logic [ADDR_W-1:0] CSR_ADDR = ADDR_W'(csr_addr(N));
    localparam logic [IW-1:0]     IDX_LAST = IW'(N - 1);

    logic [A_W-1:0]   a_mem_r [NN];
    logic [B_W-1:0]   b_mem_r [NN];
    logic [ACC_W-1:0] c_mem_r [NN];

    state_t           state_r, state_next_s;
    logic             ready_r, done_r, acc_r, err_r;
    logic [7:0]       data_out_r, rd_byte_s, csr_s;
    logic [IW-1:0]    i_r, k_r;
    logic             start_ok_s, busy_s, ab_wr_s, busy_wr_s;
    region_t          region_s;
    logic [EW-1:0]    elem_s, a_idx_s;
    logic [1:0]       byte_s;
    logic [ADDR_W-1:0] off_s;
    logic [N*B_W-1:0]   b_row_s;
    logic [N*ACC_W-1:0] c_cur_s, c_next_s;

    assign busy_s    = (state_r == ST_CLEAR) || (state_r == ST_COMPUTE);
    assign ab_wr_s   = write_en && ((region_s == RG_A) || (region_s == RG_B));
    assign busy_wr_s = ab_wr_s && busy_s;

    // Decode the byte address into region, element index and byte lane.
    always_comb begin
        region_s = RG_NONE;
        elem_s   = '0;
        byte_s   = 2'd0;
        off_s    = '0;
        if (addr < B_BASE) begin
            region_s = RG_A;
            elem_s   = EW'(addr >> 1);
            byte_s   = {1'b0, addr[0]};
        end else if (addr < C_BASE) begin
            region_s = RG_B;
            off_s    = addr - B_BASE;
            elem_s   = EW'(off_s);
        end else if (addr < CSR_ADDR) begin
            region_s = RG_C;
            off_s    = addr - C_BASE;
            elem_s   = EW'(off_s >> 2);
            byte_s   = off_s[1:0];
        end else if (addr == CSR_ADDR) begin
            region_s = RG_CSR;
        end else begin
            region_s = RG_NONE;
        end
    end

    // Assemble the CSR view and select the addressed read byte.
    always_comb begin
        csr_s               = 8'h00;
        csr_s[CSR_ACC_BIT]  = acc_r;
        csr_s[CSR_BUSY_BIT] = busy_s;
        csr_s[CSR_DONE_BIT] = done_r;
        csr_s[CSR_ERR_BIT]  = err_r;
        case (region_s)
            RG_A:    rd_byte_s = a_mem_r[elem_s][{byte_s[0], 3'b000} +: 8];
            RG_B:    rd_byte_s = 8'(b_mem_r[elem_s]);
            RG_C:    rd_byte_s = c_mem_r[elem_s][{byte_s, 3'b000} +: 8];
            RG_CSR:  rd_byte_s = csr_s;
            default: rd_byte_s = 8'h00;
        endcase
    end

    // Next-state logic; a start is only honoured from IDLE or DONE.
    always_comb begin
        state_next_s = state_r;
        start_ok_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok_s   = 1'b1;
                    state_next_s = acc_r ? ST_COMPUTE : ST_CLEAR;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_CLEAR: state_next_s = ST_COMPUTE;
            ST_COMPUTE: begin
                if ((i_r == IDX_LAST) && (k_r == IDX_LAST)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_COMPUTE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register with ready/done registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_DONE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Row/inner indices walk k fastest and return to zero after the last MAC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_r <= '0;
            k_r <= '0;
        end else if (start_ok_s) begin
            i_r <= '0;
            k_r <= '0;
        end else if (state_r == ST_COMPUTE) begin
            if (k_r == IDX_LAST) begin
                k_r <= '0;
                i_r <= (i_r == IDX_LAST) ? '0 : i_r + 1'b1;
            end else begin
                k_r <= k_r + 1'b1;
            end
        end
    end

    assign a_idx_s = EW'(int'(i_r) * N + int'(k_r));

    // Gather B row k and C row i for the MAC lanes.
    always_comb begin
        b_row_s = '0;
        c_cur_s = '0;
        for (int j = 0; j < N; j++) begin
            b_row_s[j*B_W +: B_W]     = b_mem_r[EW'(int'(k_r) * N + j)];
            c_cur_s[j*ACC_W +: ACC_W] = c_mem_r[EW'(int'(i_r) * N + j)];
        end
    end

    mac_row #(
        .N      (N),
        .A_W    (A_W),
        .B_W    (B_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac_row (
        .a_val  (a_mem_r[a_idx_s]),
        .b_row  (b_row_s),
        .c_cur  (c_cur_s),
        .c_next (c_next_s)
    );

    // Host writes into A and B; dropped while the engine is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NN; e++) begin
                a_mem_r[e] <= '0;
                b_mem_r[e] <= '0;
            end
        end else if (ab_wr_s && !busy_s) begin
            if (region_s == RG_A) begin
                a_mem_r[elem_s][{byte_s[0], 3'b000} +: 8] <= data_in;
            end else begin
                b_mem_r[elem_s] <= data_in[B_W-1:0];
            end
        end
    end

    // C storage: zeroed in CLEAR, row i updated every COMPUTE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NN; e++) begin
                c_mem_r[e] <= '0;
            end
        end else if (state_r == ST_CLEAR) begin
            for (int e = 0; e < NN; e++) begin
                c_mem_r[e] <= '0;
            end
        end else if (state_r == ST_COMPUTE) begin
            for (int j = 0; j < N; j++) begin
                c_mem_r[EW'(int'(i_r) * N + j)] <= c_next_s[j*ACC_W +: ACC_W];
            end
        end
    end

    // CSR: ACC is host-writable; ERR is sticky, a busy-time load beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (write_en && (region_s == RG_CSR)) begin
                acc_r <= data_in[CSR_ACC_BIT];
            end
            if (busy_wr_s) begin
                err_r <= 1'b1;
            end else if (write_en && (region_s == RG_CSR) && data_in[CSR_ERR_BIT]) begin
                err_r <= 1'b0;
            end
        end
    end

    // Registered read port; a simultaneous write suppresses the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_r <= 8'h00;
        end else if (read_en && !write_en) begin
            data_out_r <= rd_byte_s;
        end
    end

    assign data_out = data_out_r;
    assign ready    = ready_r;
    assign done     = done_r;

endmodule
